inst_cache: RTL and testbench

Direct-mapped, single-word-line instruction cache that serves the fetch stage through the slave side of `i_fetch_inst` and refills from memory as a master on `i_membus`. It sits between the IF stage and the instruction memory. Hits return in the same cycle. Misses assert a stall request until one refill read completes.

---
 rtl/inst_cache_pkg.sv | 18 +
 rtl/inst_cache_if.sv | 24 ++
 rtl/inst_cache_array.sv | 45 ++++
 rtl/inst_cache.sv | 103 ++++++++++
 tb/tb_inst_cache.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/inst_cache_pkg.sv
// Shared project types plus the instruction-cache additions (FSM encoding, default size).
package project_types;

   typedef logic        chip_en_t;
   typedef logic [31:0] inst_addr_t;
   typedef logic [31:0] inst_data_t;
   typedef logic [31:0] ram_addr_t;
   typedef logic [31:0] ram_data_t;

   typedef enum logic [1:0] {
      ICACHE_IDLE = 2'd0,
      ICACHE_REQ  = 2'd1,
      ICACHE_WAIT = 2'd2
   } icache_state_t;

   localparam int ICACHE_LINES_DEFAULT = 64;

endpackage

// File: rtl/inst_cache_if.sv
// Fetch-side and memory-bus interfaces used by the instruction cache.
interface i_fetch_inst;
   import project_types::*;

   chip_en_t   en;
   inst_addr_t addr;
   inst_data_t data;

   modport master (output en, output addr, input data);
   modport slave  (input en, input addr, output data);
endinterface

interface i_membus;
   import project_types::*;

   chip_en_t  we;
   chip_en_t  ce;
   ram_addr_t addr;
   ram_data_t write;
   ram_data_t read;

   modport master (output we, output ce, output addr, output write, input read);
   modport slave  (input we, input ce, input addr, input write, output read);
endinterface

// File: rtl/inst_cache_array.sv
// Direct-mapped line storage: valid/tag/word per line, combinational read, single write port.
module icache_array
   import project_types::*;
#(
   parameter int LINES = ICACHE_LINES_DEFAULT,
   parameter int TAG_W = 24
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic [$clog2(LINES)-1:0] rd_idx,
   output logic                     rd_valid,
   output logic [TAG_W-1:0]         rd_tag,
   output inst_data_t               rd_data,
   input  logic                     wr_en,
   input  logic [$clog2(LINES)-1:0] wr_idx,
   input  logic [TAG_W-1:0]         wr_tag,
   input  inst_data_t               wr_data
);

   logic [LINES-1:0] valid;
   logic [TAG_W-1:0] tags  [LINES];
   inst_data_t       words [LINES];

   // Only the valid bits are control state; tags and words need no reset.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tags[wr_idx]  <= wr_tag;
         words[wr_idx] <= wr_data;
      end
   end

   assign rd_valid = valid[rd_idx];
   assign rd_tag   = tags[rd_idx];
   assign rd_data  = words[rd_idx];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped single-word-line instruction cache: combinational hit path, one-read refill FSM.
module inst_cache
   import project_types::*;
#(
   parameter int LINES       = ICACHE_LINES_DEFAULT,
   parameter int MEM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   i_fetch_inst.slave  fetch,
   i_membus.master     mem,
   input  logic        flush,
   output logic        stall_req
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = 30 - IDX_W;

   localparam logic [1:0] S_IDLE = ICACHE_IDLE;
   localparam logic [1:0] S_REQ  = ICACHE_REQ;
   localparam logic [1:0] S_WAIT = ICACHE_WAIT;

   logic [1:0]       state;
   logic [3:0]       cnt;
   logic [29:0]      miss_word;

   logic [IDX_W-1:0] rd_idx;
   logic [TAG_W-1:0] req_tag;
   logic             rd_valid;
   logic [TAG_W-1:0] rd_tag;
   inst_data_t       rd_data;
   logic             lookup_hit;
   logic             hit;
   logic             miss;
   logic             fill;

   assign rd_idx     = fetch.addr[IDX_W+1:2];
   assign req_tag    = fetch.addr[31:IDX_W+2];
   assign lookup_hit = rd_valid && (rd_tag == req_tag);

   // Outputs are forced quiet during the reset cycle, whatever state is held.
   assign hit  = !rst && (state == S_IDLE) && fetch.en && lookup_hit;
   assign miss = !rst && (state == S_IDLE) && fetch.en && !lookup_hit;
   assign fill = !rst && !flush && (state == S_WAIT) && (cnt == 4'd1);

   assign fetch.data = hit ? rd_data : '0;
   assign stall_req  = miss || (!rst && (state != S_IDLE));

   assign mem.ce    = !rst && (state == S_REQ);
   assign mem.we    = 1'b0;
   assign mem.addr  = mem.ce ? {miss_word, 2'b00} : '0;
   assign mem.write = '0;

   icache_array #(
      .LINES (LINES),
      .TAG_W (TAG_W)
   ) u_array (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .rd_idx   (rd_idx),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .wr_en    (fill),
      .wr_idx   (miss_word[IDX_W-1:0]),
      .wr_tag   (miss_word[29:IDX_W]),
      .wr_data  (mem.read)
   );

   // Flush aborts any refill and, in an IDLE miss cycle, suppresses the transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         miss_word <= '0;
      end else if (flush) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (miss) begin
                  miss_word <= fetch.addr[31:2];
                  state     <= S_REQ;
               end
            end
            S_REQ: begin
               cnt   <= 4'(MEM_LATENCY);
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (cnt == 4'd1) begin
                  state <= S_IDLE;
               end
               cnt <= cnt - 4'd1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_cache.sv
// Randomized bench: two caches (latency 1 and 4) checked every cycle against a line-table model.
module tb_inst_cache;
   localparam int LINES = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        en;
   logic [31:0] addr;
   int          cyc = 0;

   int n_checks = 0;
   int n_fail   = 0;

   i_fetch_inst f0 ();
   i_fetch_inst f1 ();
   i_membus     m0 ();
   i_membus     m1 ();

   logic        stall [2];
   logic [31:0] odata [2];
   logic        oce   [2];
   logic        owe   [2];
   logic [31:0] oaddr [2];
   logic [31:0] owr   [2];
   logic [31:0] rd    [2];

   assign f0.en = en;  assign f0.addr = addr;
   assign f1.en = en;  assign f1.addr = addr;
   assign m0.read = rd[0];
   assign m1.read = rd[1];
   assign odata[0] = f0.data;  assign odata[1] = f1.data;
   assign oce[0]   = m0.ce;    assign oce[1]   = m1.ce;
   assign owe[0]   = m0.we;    assign owe[1]   = m1.we;
   assign oaddr[0] = m0.addr;  assign oaddr[1] = m1.addr;
   assign owr[0]   = m0.write; assign owr[1]   = m1.write;

   inst_cache #(.LINES(LINES), .MEM_LATENCY(1)) dut0 (
      .clk(clk), .rst(rst), .fetch(f0), .mem(m0), .flush(flush), .stall_req(stall[0]));
   inst_cache #(.LINES(LINES), .MEM_LATENCY(4)) dut1 (
      .clk(clk), .rst(rst), .fetch(f1), .mem(m1), .flush(flush), .stall_req(stall[1]));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'h2408_0001;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   // Reference: per-line table plus a count of stall cycles left in the current refill.
   int          lat  [2] = '{1, 4};
   int          rem  [2] = '{0, 0};
   logic [31:0] pend [2];
   logic        mv   [2][LINES];
   logic [31:0] ma   [2][LINES];
   logic [31:0] md   [2][LINES];
   int          req_cyc [2] = '{0, 0};
   logic [31:0] req_addr[2];
   logic        req_v   [2] = '{1'b0, 1'b0};

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         logic        e_stall, e_ce, hitm;
         logic [31:0] e_data, e_addr, aligned;
         int          idx;

         // External memory: correct word exactly lat cycles after ce, garbage otherwise.
         if (oce[k]) begin
            req_cyc[k] = cyc; req_addr[k] = oaddr[k]; req_v[k] = 1'b1;
         end
         rd[k] = (req_v[k] && cyc == req_cyc[k] + lat[k]) ? mem_word(req_addr[k]) : $urandom;

         aligned = addr & ~32'h3;
         idx     = int'((addr >> 2) % LINES);
         e_stall = 1'b0; e_ce = 1'b0; e_data = '0; e_addr = '0; hitm = 1'b0;
         if (!rst) begin
            if (rem[k] == 0) begin
               if (en) begin
                  hitm = mv[k][idx] && (ma[k][idx] == aligned);
                  if (hitm) e_data = md[k][idx];
                  else      e_stall = 1'b1;
               end
            end else begin
               e_stall = 1'b1;
               if (rem[k] == lat[k] + 1) begin
                  e_ce = 1'b1; e_addr = pend[k];
               end
            end
         end

         check($sformatf("d%0d_stall", k), 32'(stall[k]), 32'(e_stall));
         check($sformatf("d%0d_data", k),  odata[k], e_data);
         check($sformatf("d%0d_ce", k),    32'(oce[k]), 32'(e_ce));
         check($sformatf("d%0d_maddr", k), oaddr[k], e_addr);
         check($sformatf("d%0d_we", k),    32'(owe[k]), 32'h0);
         check($sformatf("d%0d_wdata", k), owr[k], 32'h0);

         if (rst || flush) begin
            for (int i = 0; i < LINES; i++) mv[k][i] = 1'b0;
            rem[k] = 0;
         end else if (rem[k] == 0) begin
            if (en && !hitm) begin
               rem[k] = lat[k] + 1; pend[k] = aligned;
            end
         end else if (rem[k] == 1) begin
            idx = int'((pend[k] >> 2) % LINES);
            mv[k][idx] = 1'b1; ma[k][idx] = pend[k]; md[k][idx] = mem_word(pend[k]);
            rem[k] = 0;
         end else begin
            rem[k] = rem[k] - 1;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic fetch_for(input logic [31:0] a, input int n);
      en = 1'b1; addr = a;
      step(n);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; en = 1'b0; addr = '0;
      #1;
      step(3);
      rst = 1'b0;
      step(1);

      fetch_for(32'h0000_0100, 8);
      fetch_for(32'h0000_0100, 2);
      fetch_for(32'h0000_0102, 2);
      fetch_for(32'h0000_0200, 8);
      fetch_for(32'h0000_0100, 8);

      // Flush while both caches sit in WAIT, then refetch.
      fetch_for(32'h0000_0340, 2);
      flush = 1'b1; step(1); flush = 1'b0;
      step(8);

      // Reset while both caches sit in WAIT; a previously cached line must miss.
      fetch_for(32'h0000_0480, 2);
      rst = 1'b1; step(1); rst = 1'b0;
      fetch_for(32'h0000_0100, 8);
      en = 1'b0; step(2);

      for (int i = 0; i < 3000; i++) begin
         en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 3) == 0)
            addr = (32'($urandom_range(0, 1)) << 31) | (32'($urandom_range(0, 3)) << 8) |
                   (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
         flush = ($urandom_range(0, 39) == 0);
         rst   = ($urandom_range(0, 149) == 0);
         step(1);
      end
      rst = 1'b0; flush = 1'b0; en = 1'b0;
      step(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
